// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
//
// Shares one serial system bus between NUM_MASTERS master ports. Requests are
// collected from mbreq, a registered one-hot grant is issued on mbgrant and
// msel steers the bus mux. Split transactions are supported: a split slave
// pulses ssplit to park the current owner (flagged on msplit) and free the bus.
// The parked owner is re-granted ahead of everyone else once the slave pulses
// sready.
//
// Optional feature macro: ROUND_ROBIN_EN
//   undefined : fixed priority, lowest index wins
//   defined   : rotating priority starting at rr_ptr, updated on fresh grants
//
// Ports
//   clk         in   system clock, all state on rising edge
//   rstn        in   asynchronous active-low reset
//   mbreq       in   per-master request, level, held for the whole transaction
//   mbgrant     out  one-hot (or zero) registered grant
//   msplit      out  one-hot (or zero) "parked by split slave"
//   msel        out  index of current/last owner
//   bus_busy    out  high while any grant is asserted
//   ssplit      in   slave split request, 1-cycle pulse in the data phase
//   sready      in   split slave ready to resume, 1-cycle pulse
//   dbg_state_o out  FSM state (0 = IDLE, 1 = BUSY)
//
// Handshake: a master owns the bus from the cycle mbgrant[i] is seen high until
// it drops mbreq[i]; the grant falls on the next edge and at least one IDLE
// cycle with no grant separates consecutive owners.
// -----------------------------------------------------------------------------
module bus_arbiter #(
   parameter int NUM_MASTERS = 2,
   parameter int MSEL_WIDTH  = 1
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic [NUM_MASTERS-1:0] mbreq,
   output logic [NUM_MASTERS-1:0] mbgrant,
   output logic [NUM_MASTERS-1:0] msplit,
   output logic [MSEL_WIDTH-1:0]  msel,
   output logic                   bus_busy,
   input  logic                   ssplit,
   input  logic                   sready,
   output logic                   dbg_state_o
);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_e;

   state_e                 state_q, state_d;
   logic [NUM_MASTERS-1:0] grant_q, grant_d;
   logic [NUM_MASTERS-1:0] msplit_q, msplit_d;
   logic [MSEL_WIDTH-1:0]  msel_q, msel_d;
   logic                   split_pend_q, split_pend_d;
   logic                   split_rdy_q, split_rdy_d;
   logic [MSEL_WIDTH-1:0]  split_own_q, split_own_d;

   logic                   pend_live;   // split pending and owner still requesting
   logic [NUM_MASTERS-1:0] split_mask;
   logic [NUM_MASTERS-1:0] elig;
   logic                   found;
   logic [MSEL_WIDTH-1:0]  winner;

   // A pending split whose owner has dropped its request is abandoned; only a
   // live split masks its owner out of fresh arbitration.
   always_comb begin
      pend_live  = split_pend_q && mbreq[split_own_q];
      split_mask = '0;
      if (pend_live) split_mask[split_own_q] = 1'b1;
      elig = mbreq & ~split_mask;
   end

`ifdef ROUND_ROBIN_EN
   logic [MSEL_WIDTH-1:0]    rr_ptr_q, rr_ptr_d;
   logic [2*NUM_MASTERS-1:0] elig_dbl;

   // Rotate the eligible vector so bit 0 corresponds to rr_ptr, take the
   // lowest set bit, then map back to an absolute index modulo NUM_MASTERS.
   always_comb begin
      int sum;
      sum      = 0;
      found    = 1'b0;
      winner   = '0;
      elig_dbl = {elig, elig} >> rr_ptr_q;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (!found && elig_dbl[i]) begin
            found = 1'b1;
            sum   = int'(rr_ptr_q) + i;
            if (sum >= NUM_MASTERS) sum = sum - NUM_MASTERS;
            winner = MSEL_WIDTH'(sum);
         end
      end
   end
`else
   always_comb begin
      found  = |elig;
      winner = '0;
      for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
         if (elig[i]) winner = MSEL_WIDTH'(i);
      end
   end
`endif

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      msplit_d     = msplit_q;
      msel_d       = msel_q;
      split_pend_d = split_pend_q;
      split_rdy_d  = split_rdy_q;
      split_own_d  = split_own_q;
`ifdef ROUND_ROBIN_EN
      rr_ptr_d     = rr_ptr_q;
`endif

      // sready only counts against a split already pending; a simultaneous
      // ssplit wins and the ready pulse is lost.
      if (sready && split_pend_q && !ssplit) split_rdy_d = 1'b1;

      case (state_q)
         IDLE: begin
            if (split_pend_q && !pend_live) begin
               split_pend_d          = 1'b0;
               split_rdy_d           = 1'b0;
               msplit_d[split_own_q] = 1'b0;
            end
            if (pend_live && split_rdy_q) begin
               grant_d               = '0;
               grant_d[split_own_q]  = 1'b1;
               msplit_d[split_own_q] = 1'b0;
               msel_d                = split_own_q;
               split_pend_d          = 1'b0;
               split_rdy_d           = 1'b0;
               state_d               = BUSY;
            end else if (found) begin
               grant_d         = '0;
               grant_d[winner] = 1'b1;
               msel_d          = winner;
               state_d         = BUSY;
`ifdef ROUND_ROBIN_EN
               rr_ptr_d = (winner == MSEL_WIDTH'(NUM_MASTERS - 1)) ? '0 : winner + 1'b1;
`endif
            end
         end
         BUSY: begin
            if (ssplit) begin
               // One split slot: a second split only releases the bus.
               if (!split_pend_q) begin
                  split_pend_d     = 1'b1;
                  split_own_d      = msel_q;
                  msplit_d[msel_q] = 1'b1;
               end
               grant_d = '0;
               state_d = IDLE;
            end else if (!mbreq[msel_q]) begin
               grant_d = '0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= IDLE;
         grant_q      <= '0;
         msplit_q     <= '0;
         msel_q       <= '0;
         split_pend_q <= 1'b0;
         split_rdy_q  <= 1'b0;
         split_own_q  <= '0;
`ifdef ROUND_ROBIN_EN
         rr_ptr_q     <= '0;
`endif
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         msplit_q     <= msplit_d;
         msel_q       <= msel_d;
         split_pend_q <= split_pend_d;
         split_rdy_q  <= split_rdy_d;
         split_own_q  <= split_own_d;
`ifdef ROUND_ROBIN_EN
         rr_ptr_q     <= rr_ptr_d;
`endif
      end
   end

   assign mbgrant     = grant_q;
   assign msplit      = msplit_q;
   assign msel        = msel_q;
   assign bus_busy    = |grant_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter
//
// Directed bench for bus_arbiter with default parameters (2 masters, 1-bit
// msel). Each step drives the inputs just after a rising edge, pushes the
// outputs expected after the next rising edge onto exp_q, then samples 1 time
// unit after that edge and compares. Expected vector layout:
//   {state, mbgrant[1:0], msplit[1:0], msel, bus_busy}
// -----------------------------------------------------------------------------
module tb_bus_arbiter;

   localparam int N = 2;
   localparam int W = 7;

`ifdef ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   logic         clk = 1'b0;
   logic         rstn;
   logic [N-1:0] mbreq;
   logic [N-1:0] mbgrant;
   logic [N-1:0] msplit;
   logic         msel;
   logic         bus_busy;
   logic         ssplit;
   logic         sready;
   logic         dbg_state;

   always #5 clk = ~clk;

   bus_arbiter #(
      .NUM_MASTERS(2),
      .MSEL_WIDTH (1)
   ) dut (
      .clk        (clk),
      .rstn       (rstn),
      .mbreq      (mbreq),
      .mbgrant    (mbgrant),
      .msplit     (msplit),
      .msel       (msel),
      .bus_busy   (bus_busy),
      .ssplit     (ssplit),
      .sready     (sready),
      .dbg_state_o(dbg_state)
   );

   // ---------------- scoreboard ----------------
   logic [W-1:0] exp_q[$];
   int           n_checks = 0;
   int           n_fail   = 0;

   function automatic logic [W-1:0] pack_exp(input logic [1:0] eg, input logic [1:0] es,
                                             input logic esel);
      return {|eg, eg, es, esel, |eg};
   endfunction

   task automatic check(input string tag);
      logic [W-1:0] obs;
      logic [W-1:0] exp_v;
      obs = {dbg_state, mbgrant, msplit, msel, bus_busy};
      n_checks++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $error("FAIL %s: scoreboard empty, observed %b", tag, obs);
      end else begin
         exp_v = exp_q.pop_front();
         assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %b required %b ({st,gnt,split,sel,busy})", tag, obs, exp_v);
         end
      end
   endtask

   // ---------------- driver ----------------
   task automatic step(input logic [1:0] req, input logic ss, input logic sr,
                       input logic [1:0] eg, input logic [1:0] es, input logic esel,
                       input string tag);
      mbreq  = req;
      ssplit = ss;
      sready = sr;
      exp_q.push_back(pack_exp(eg, es, esel));
      @(posedge clk);
      #1;
      check(tag);
   endtask

   function automatic logic [1:0] onehot(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

   // ---------------- watchdog ----------------
   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   // ---------------- stimulus ----------------
   initial begin
      logic w;
      logic ptr;
      rstn   = 1'b0;
      mbreq  = '0;
      ssplit = 1'b0;
      sready = 1'b0;
      @(posedge clk);
      #1;
      exp_q.push_back(pack_exp(2'b00, 2'b00, 1'b0));
      check("reset_state");
      rstn = 1'b1;

      // Contention and handover gap
      step(2'b00, 0, 0, 2'b00, 2'b00, 1'b0, "idle_no_req");
      step(2'b11, 0, 0, 2'b01, 2'b00, 1'b0, "contend_m0_wins");
      step(2'b11, 0, 0, 2'b01, 2'b00, 1'b0, "m0_hold");
      step(2'b10, 0, 0, 2'b00, 2'b00, 1'b0, "m0_release_gap");
      step(2'b10, 0, 0, 2'b10, 2'b00, 1'b1, "m1_granted");
      step(2'b10, 0, 0, 2'b10, 2'b00, 1'b1, "m1_hold");
      step(2'b00, 0, 0, 2'b00, 2'b00, 1'b1, "m1_release_msel_holds");
      step(2'b11, 0, 0, 2'b01, 2'b00, 1'b0, "contend_again");
      step(2'b01, 0, 0, 2'b01, 2'b00, 1'b0, "m0_hold_no_preempt");
      step(2'b10, 0, 0, 2'b00, 2'b00, 1'b0, "m0_release2");
      // Rotating priority favours M1 here; fixed priority gives M0.
      step(2'b11, 0, 0, RR ? 2'b10 : 2'b01, 2'b00, RR, "policy_after_m0");
      step(2'b00, 0, 0, 2'b00, 2'b00, RR, "policy_release");

      // Held contention: each owner drops after three granted cycles
      ptr = 1'b0;
      for (int g = 0; g < 4; g++) begin
         w   = RR ? ptr : 1'b0;
         ptr = ~w;
         step(2'b11, 0, 0, onehot(w), 2'b00, w, "held_grant");
         step(2'b11, 0, 0, onehot(w), 2'b00, w, "held_hold1");
         step(2'b11, 0, 0, onehot(w), 2'b00, w, "held_hold2");
         step(2'b11 & ~onehot(w), 0, 0, 2'b00, 2'b00, w, "held_drop");
      end

      // Split, M1 uses the bus, then ready re-grants M0
      step(2'b01, 0, 0, 2'b01, 2'b00, 1'b0, "split_m0_grant");
      step(2'b11, 1, 0, 2'b00, 2'b01, 1'b0, "split_park_m0");
      step(2'b11, 0, 0, 2'b10, 2'b01, 1'b1, "split_m1_grant");
      step(2'b11, 0, 0, 2'b10, 2'b01, 1'b1, "split_m1_hold");
      step(2'b01, 0, 0, 2'b00, 2'b01, 1'b1, "split_m1_done");
      step(2'b01, 0, 1, 2'b00, 2'b01, 1'b1, "split_sready_idle");
      step(2'b01, 0, 0, 2'b01, 2'b00, 1'b0, "split_regrant_same_edge");
      step(2'b00, 0, 0, 2'b00, 2'b00, 1'b0, "split_m0_done");

      // Early ready while M1 busy; M0 beats a waiting M1
      step(2'b01, 0, 0, 2'b01, 2'b00, 1'b0, "early_m0_grant");
      step(2'b11, 1, 0, 2'b00, 2'b01, 1'b0, "early_park_m0");
      step(2'b11, 0, 0, 2'b10, 2'b01, 1'b1, "early_m1_grant");
      step(2'b11, 0, 1, 2'b10, 2'b01, 1'b1, "early_sready_busy");
      step(2'b01, 0, 0, 2'b00, 2'b01, 1'b1, "early_m1_release");
      step(2'b11, 0, 0, 2'b01, 2'b00, 1'b0, "early_m0_first");
      step(2'b11, 0, 0, 2'b01, 2'b00, 1'b0, "early_m0_hold");
      step(2'b10, 0, 0, 2'b00, 2'b00, 1'b0, "early_m0_done");
      step(2'b10, 0, 0, 2'b10, 2'b00, 1'b1, "early_m1_after");
      step(2'b00, 0, 0, 2'b00, 2'b00, 1'b1, "early_m1_done");

      // Abandoned split: later sready must not produce a grant
      step(2'b01, 0, 0, 2'b01, 2'b00, 1'b0, "abandon_m0_grant");
      step(2'b01, 1, 0, 2'b00, 2'b01, 1'b0, "abandon_park");
      step(2'b00, 0, 0, 2'b00, 2'b00, 1'b0, "abandon_cleared");
      step(2'b00, 0, 1, 2'b00, 2'b00, 1'b0, "abandon_sready_ignored");
      step(2'b00, 0, 0, 2'b00, 2'b00, 1'b0, "abandon_no_spurious");
      step(2'b01, 0, 0, 2'b01, 2'b00, 1'b0, "abandon_m0_fresh");
      step(2'b00, 0, 0, 2'b00, 2'b00, 1'b0, "abandon_m0_done");

      // ssplit and sready together: ready is lost
      step(2'b01, 0, 0, 2'b01, 2'b00, 1'b0, "both_m0_grant");
      step(2'b01, 1, 1, 2'b00, 2'b01, 1'b0, "both_split_wins");
      step(2'b01, 0, 0, 2'b00, 2'b01, 1'b0, "both_ready_dropped");
      step(2'b01, 0, 1, 2'b00, 2'b01, 1'b0, "both_sready_again");
      step(2'b01, 0, 0, 2'b01, 2'b00, 1'b0, "both_regrant");

      // Asynchronous reset in the middle of BUSY
      rstn = 1'b0;
      #2;
      exp_q.push_back(pack_exp(2'b00, 2'b00, 1'b0));
      check("async_reset_immediate");
      @(posedge clk);
      #1;
      exp_q.push_back(pack_exp(2'b00, 2'b00, 1'b0));
      check("reset_held");
      rstn  = 1'b1;
      mbreq = 2'b00;
      step(2'b10, 0, 0, 2'b10, 2'b00, 1'b1, "post_reset_grant");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
